spi_ram_ctrl: RTL
=================

# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes each 10-bit `rx_data` word the slave emits on `rx_valid` and performs address latch, write, or read. For reads it returns a byte on `tx_data`/`tx_valid`, which the slave shifts out on MISO. Write and read each keep an independent address pointer that auto-increments, so one address command can be followed by a burst of data commands.

## Interface
- `MEM_DEPTH`, 256, number of byte locations
- `ADDR_SIZE`, 8, address width; `MEM_DEPTH` ≤ 2**`ADDR_SIZE`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `rx_data`  in  10  command word from the SPI slave: [9:8] command, [7:0] payload
- `rx_valid`  in  1  `rx_data` valid this cycle; each high cycle is one command
- `tx_data`  out  8  read data returned to the SPI slave
- `tx_valid`  out  1  one-cycle pulse: `tx_data` updated by a read
- `cmd_err`  out  1  one-cycle pulse: protocol or range error on the command just taken

## Operation
Command encoding, from `rx_data[9:8]`:
- 00 WR_ADDR
  - `wr_ptr` ← payload[ADDR_SIZE-1:0].
  - Set `wr_armed`.
- 01 WR_DATA
  - If `wr_armed` and `wr_ptr` < MEM_DEPTH: mem[`wr_ptr`] ← payload, then `wr_ptr` ← `wr_ptr`+1.
  - If `wr_armed` but `wr_ptr` ≥ MEM_DEPTH: no write, `cmd_err` pulse.
  - If not armed: no write, `cmd_err` pulse, `wr_ptr` unchanged.
- 10 RD_ADDR
  - `rd_ptr` ← payload.
  - Set `rd_armed`.
- 11 RD_DATA
  - Payload is ignored.
  - If `rd_armed` and in range: `tx_data` ← mem[`rd_ptr`], `tx_valid` pulse, `rd_ptr` ← `rd_ptr`+1.
  - If armed but out of range: `tx_data` ← 8'h00, `tx_valid` pulse, `cmd_err` pulse.
  - If not armed: no `tx_valid`, `cmd_err` pulse.

General rules:
- Pointer increment wraps MEM_DEPTH-1 → 0.
- When `rx_valid` is low, nothing changes. `tx_valid` and `cmd_err` are low.
- `wr_armed` and `rd_armed` stay set until reset. Re-issuing an address command only reloads the pointer.
- `tx_data` holds its last value until the next RD_DATA that returns data.
- Memory contents are not reset and are unknown after power-up. They are retained across `rst_n`.

## Timing
- Reset values: `tx_data`=8'h00, `tx_valid`=0, `cmd_err`=0, `wr_ptr`=`rd_ptr`=0, `wr_armed`=`rd_armed`=0.
- Reset takes effect immediately on `rst_n` falling, without waiting for `clk`.
- Reset mid-burst: both armed flags clear. The next data command without a new address command gives `cmd_err`.
- Write latency: an RD_DATA in the cycle after a WR_DATA to the same address returns the new byte.
- Read latency:
  - RD_DATA is sampled at edge N.
  - `tx_data`/`tx_valid` are registered at edge N and visible during cycle N+1.
  - `tx_valid` is high for exactly that one cycle.
- `cmd_err` is registered and aligned with the same edge as the command that caused it.
- Back-to-back: `rx_valid` high for consecutive cycles is accepted as consecutive commands.
- Back-to-back throughput: one command per cycle; N RD_DATA in a row give N `tx_valid` pulses.

## Structure
- Shared package `shared_pkg` holds:
  - `spi_cmd_e` (2-bit enum: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11);
  - localparams `CMD_MSB`=9 and `CMD_LSB`=8.
- `spi_ram_ctrl` contains the decoder, pointers, armed flags, output registers, and error logic.
- Storage goes in the sub-module `spi_ram_array`:
  - parameterised by MEM_DEPTH and ADDR_SIZE;
  - one synchronous write port (`we`, `waddr`, `wdata`);
  - one registered read port (`re`, `raddr`, `rdata`, one-cycle latency).
- `spi_ram_ctrl` aligns `tx_valid` with `rdata`.

## Test plan
- Reset, then RD_DATA 0x3_00 before any RD_ADDR → `cmd_err`=1 for one cycle, `tx_valid` stays 0, `tx_data`=0x00.
- Write then read one location:
  - stimulus 0x0_3A, 0x1_C5, 0x2_3A, 0x3_00, one cycle apart;
  - response: `tx_valid` pulse one cycle after the last command, `tx_data`=0xC5, no `cmd_err`.
- Write burst with wrap:
  - stimulus WR_ADDR 0xFE, then WR_DATA 0x11, 0x22, 0x33;
  - response: addresses 0xFE, 0xFF, 0x00 hold 0x11, 0x22, 0x33;
  - then RD_ADDR 0xFE and three RD_DATA back-to-back → three consecutive `tx_valid` with 0x11, 0x22, 0x33.
- Reset mid-burst:
  - stimulus WR_ADDR 0x10, WR_DATA 0xAA, assert `rst_n`=0 between clock edges, release, then WR_DATA 0xBB;
  - response: outputs go to 0 at once, `cmd_err` pulses, 0x11 not written, 0x10 still reads 0xAA after re-arming.
- Hold and idle: after a read returning 0x5A, hold `rx_valid` low 20 cycles → `tx_data` stays 0x5A, `tx_valid`/`cmd_err` stay 0.
- Range check with MEM_DEPTH=200:
  - WR_ADDR 0xC8 then WR_DATA 0x77 → `cmd_err`, no write;
  - RD_ADDR 0xC8 then RD_DATA → `tx_valid`=1, `tx_data`=0x00, `cmd_err`=1.

Source files
------------

// File: rtl/shared_pkg.sv
// ---------------------------------------------------------------------------
// shared_pkg
// Command encoding and field positions shared by the SPI RAM controller and
// its storage array.
// Contents:
//   spi_cmd_e        2-bit command opcode carried in rx_data[9:8]
//   CMD_MSB/CMD_LSB  bit range of the opcode inside a 10-bit command word
//   DATA_W           width of one stored byte / payload
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shared_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  localparam int CMD_MSB = 9;
  localparam int CMD_LSB = 8;
  localparam int DATA_W  = 8;

endpackage : shared_pkg

`default_nettype wire

// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl_if
// Word-level link between the SPI slave shifter and the RAM controller.
// Signals:
//   rx_data   [9:0]  command word: [9:8] opcode, [7:0] payload
//   rx_valid         rx_data holds a new command this cycle
//   tx_data   [7:0]  byte returned for the slave to shift out on MISO
//   tx_valid         one-cycle pulse, tx_data refreshed by a read
//   cmd_err          one-cycle pulse, last command was rejected
// Modports:
//   master  SPI slave side (drives commands, receives read data)
//   slave   RAM controller side
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_ram_ctrl_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid,
    input  cmd_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid,
    output cmd_err
  );
endinterface : spi_ram_ctrl_if

`default_nettype wire

// File: rtl/spi_ram_array.sv
// ---------------------------------------------------------------------------
// spi_ram_array
// Byte-wide single-clock RAM with one synchronous write port and one
// registered read port (data appears the cycle after re is sampled).
// Contents are never reset.
// Ports:
//   clk    clock
//   we     write enable;  waddr/wdata sampled on the rising edge
//   re     read enable;   rdata <= mem[raddr] on the rising edge, else holds
//   rdata  registered read data
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_ram_array
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Callers only assert we/re with an address below MEM_DEPTH.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : spi_ram_array

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl
// Command decoder in front of a byte RAM. Each rx_valid cycle carries one
// command: write-address, write-data, read-address or read-data. Write and
// read keep separate auto-incrementing pointers, so one address command can
// be followed by a burst of data commands.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (RAM contents are kept)
//   bus    spi_ram_ctrl_if.slave: rx_data/rx_valid in,
//          tx_data/tx_valid/cmd_err out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_ram_ctrl
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8   // must not exceed the 8-bit payload
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_ram_ctrl_if.slave bus
);

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic                 r_wr_armed;
  logic                 r_rd_armed;
  logic                 r_tx_valid;
  logic                 r_cmd_err;
  // Forces tx_data to zero after reset and after an out-of-range read,
  // because the RAM read register itself is neither reset nor loaded then.
  logic                 r_tx_zero;

  spi_cmd_e             w_cmd;
  logic [DATA_W-1:0]    w_payload;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_we;
  logic                 w_re;
  logic [DATA_W-1:0]    w_rdata;

  // Increment with wrap at the configured depth, not at 2**ADDR_SIZE.
  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    if (int'(p) == MEM_DEPTH - 1) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign w_cmd         = spi_cmd_e'(bus.rx_data[CMD_MSB:CMD_LSB]);
  assign w_payload     = bus.rx_data[CMD_LSB-1:0];
  assign w_wr_in_range = (int'(r_wr_ptr) < MEM_DEPTH);
  assign w_rd_in_range = (int'(r_rd_ptr) < MEM_DEPTH);

  assign w_we = bus.rx_valid && (w_cmd == WR_DATA) && r_wr_armed && w_wr_in_range;
  assign w_re = bus.rx_valid && (w_cmd == RD_DATA) && r_rd_armed && w_rd_in_range;

  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata (w_payload),
    .re    (w_re),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_armed <= 1'b0;
      r_rd_armed <= 1'b0;
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_tx_zero  <= 1'b1;
    end else begin
      r_tx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (bus.rx_valid) begin
        case (w_cmd)
          WR_ADDR: begin
            r_wr_ptr   <= w_payload[ADDR_SIZE-1:0];
            r_wr_armed <= 1'b1;
          end
          WR_DATA: begin
            if (w_we) begin
              r_wr_ptr <= ptr_inc(r_wr_ptr);
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          RD_ADDR: begin
            r_rd_ptr   <= w_payload[ADDR_SIZE-1:0];
            r_rd_armed <= 1'b1;
          end
          RD_DATA: begin
            if (!r_rd_armed) begin
              r_cmd_err <= 1'b1;
            end else if (w_rd_in_range) begin
              r_tx_valid <= 1'b1;
              r_tx_zero  <= 1'b0;
              r_rd_ptr   <= ptr_inc(r_rd_ptr);
            end else begin
              // Armed but past the end: answer with a zero byte and flag it.
              r_tx_valid <= 1'b1;
              r_tx_zero  <= 1'b1;
              r_cmd_err  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // r_tx_valid and the RAM read register are loaded on the same edge.
  assign bus.tx_data  = r_tx_zero ? '0 : w_rdata;
  assign bus.tx_valid = r_tx_valid;
  assign bus.cmd_err  = r_cmd_err;

endmodule : spi_ram_ctrl

`default_nettype wire
